me_best_match: RTL and testbench

//  Downstream of the motion-estimation controller and SAD tree. Consumes one SAD per valid cycle
//  in the fixed serpentine search order; tracks the minimum SAD and its motion vector.

---
 rtl/me_pkg.sv | 31 +++
 rtl/me_scan_pos.sv | 46 ++++
 rtl/me_best_match.sv | 102 ++++++++++
 tb/tb_me_best_match.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimation best-match tracker.
package me_pkg;

    localparam int MACRO_DIM  = 16;
    localparam int SEARCH_DIM = 48;
    localparam int SAD_W      = 16;
    localparam int MV_W       = 6;
    localparam int ZERO_BIAS  = 64;

    // Candidates per axis: 2R+1 where R = (SEARCH_DIM-MACRO_DIM)/2.
    function automatic int me_range(input int macro_dim, input int search_dim);
        return search_dim - macro_dim + 1;
    endfunction

    localparam int R        = (SEARCH_DIM - MACRO_DIM) / 2;
    localparam int RANGE    = me_range(MACRO_DIM, SEARCH_DIM);
    localparam int CNT_W    = $clog2(RANGE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } me_bm_state_t;

    typedef struct packed {
        logic signed [MV_W-1:0] mv_x;
        logic signed [MV_W-1:0] mv_y;
        logic [SAD_W-1:0]       sad;
    } me_cand_t;

endpackage

// File: rtl/me_scan_pos.sv
// Column-serpentine scan position: row/col counters and the signed MV of the
// candidate whose SAD is currently presented.
module me_scan_pos
    import me_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            advance,
    output logic [MV_W-1:0] cur_mv_x,
    output logic [MV_W-1:0] cur_mv_y,
    output logic            last
);

    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;

    // Row counts down the column, wraps and bumps col; clear restarts the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (row == CNT_W'(RANGE - 1)) begin
                row <= '0;
                col <= (col == CNT_W'(RANGE - 1)) ? '0 : col + 1'b1;
            end else begin
                row <= row + 1'b1;
            end
        end
    end

    // Even columns climb from -R, odd columns descend from +R.
    always_comb begin
        cur_mv_x = MV_W'(col) - MV_W'(R);
        if (col[0])
            cur_mv_y = MV_W'(R) - MV_W'(row);
        else
            cur_mv_y = MV_W'(row) - MV_W'(R);
        last = (row == CNT_W'(RANGE - 1)) && (col == CNT_W'(RANGE - 1));
    end

endmodule

// File: rtl/me_best_match.sv
// Best-match tracker: keeps the minimum SAD and its motion vector over one
// full serpentine search, then holds the winner until accepted.
// Optional build macro ME_ZERO_BIAS_EN credits the (0,0) candidate by ZERO_BIAS.
//
// state | meaning
// IDLE  | ready for start, result registers idle
// SCAN  | consuming one SAD per sad_valid in scan order
// HOLD  | out_valid asserted, waiting for out_ready
module me_best_match
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ready,
    input  logic             sad_valid,
    input  logic [SAD_W-1:0] sad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MV_W-1:0]  mv_x,
    output logic [MV_W-1:0]  mv_y,
    output logic [SAD_W-1:0] min_sad,
    output logic             overrun
);

    me_bm_state_t     state;
    me_cand_t         best;
    logic [MV_W-1:0]  cur_mv_x;
    logic [MV_W-1:0]  cur_mv_y;
    logic             last;
    logic [SAD_W-1:0] sad_eff;
    logic             take;

    me_scan_pos u_scan_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == IDLE && start),
        .advance  (state == SCAN && sad_valid),
        .cur_mv_x (cur_mv_x),
        .cur_mv_y (cur_mv_y),
        .last     (last)
    );

    // Effective SAD (optionally biased toward the zero vector) and strict-less compare.
    always_comb begin
        sad_eff = sad;
`ifdef ME_ZERO_BIAS_EN
        if (cur_mv_x == '0 && cur_mv_y == '0)
            sad_eff = (sad > SAD_W'(ZERO_BIAS)) ? sad - SAD_W'(ZERO_BIAS) : '0;
`endif
        take = (sad_eff < best.sad);
    end

    // Control FSM with registered handshake, result and overrun outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            best      <= '{mv_x: '0, mv_y: '0, sad: '1};
        end else begin
            overrun <= sad_valid && (state != SCAN);
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        ready <= 1'b0;
                        best  <= '{mv_x: '0, mv_y: '0, sad: '1};
                    end
                end
                SCAN: begin
                    if (sad_valid) begin
                        if (take)
                            best <= '{mv_x: cur_mv_x, mv_y: cur_mv_y, sad: sad_eff};
                        if (last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        ready     <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ready     <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mv_x    = best.mv_x;
    assign mv_y    = best.mv_y;
    assign min_sad = best.sad;

endmodule

// File: tb/tb_me_best_match.sv
// Self-checking bench for me_best_match: directed search-window patterns and
// randomized SADs against a scan-order reference model.
module tb_me_best_match;

    localparam int NC = 33 * 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic        sad_valid = 1'b0;
    logic [15:0] sad = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  mv_x;
    logic [5:0]  mv_y;
    logic [15:0] min_sad;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;
    int sads[NC];

    me_best_match dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ready     (ready),
        .sad_valid (sad_valid),
        .sad       (sad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mv_x      (mv_x),
        .mv_y      (mv_y),
        .min_sad   (min_sad),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input int x, input int y);
        int c;
        int r;
        c = x + 16;
        r = (c % 2 == 0) ? (y + 16) : (16 - y);
        return c * 33 + r;
    endfunction

    function automatic int mvx_of(input int k);
        return k / 33 - 16;
    endfunction

    function automatic int mvy_of(input int k);
        int c;
        c = k / 33;
        return (c % 2 == 0) ? (k % 33 - 16) : (16 - k % 33);
    endfunction

    function automatic int eff_of(input int k);
`ifdef ME_ZERO_BIAS_EN
        if (mvx_of(k) == 0 && mvy_of(k) == 0)
            return (sads[k] > 64) ? sads[k] - 64 : 0;
`endif
        return sads[k];
    endfunction

    // Reference: lowest effective SAD over scan order, earliest wins ties.
    task automatic model_best(output int ex, output int ey, output int es);
        ex = 0; ey = 0; es = 65535;
        for (int k = 0; k < NC; k++) begin
            if (eff_of(k) < es) begin
                es = eff_of(k);
                ex = mvx_of(k);
                ey = mvy_of(k);
            end
        end
    endtask

    task automatic fill(input int v);
        for (int k = 0; k < NC; k++) sads[k] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL wait_ready: ready=%b required 1 within 100 cycles", ready);
        end
    endtask

    // Feed sads[0..limit-1]; gaps randomly inserted when gap_en; a stray start
    // pulse is injected during a gap to show it is ignored mid-scan.
    task automatic feed(input int limit, input bit gap_en);
        wait_ready();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (gap_en && $urandom_range(0, 3) == 0) begin
                sad_valid = 1'b0;
                start = ($urandom_range(0, 1) == 1);
                repeat ($urandom_range(1, 3)) tick();
                start = 1'b0;
            end
            sad_valid = 1'b1;
            sad = 16'(sads[k]);
            if (k == NC - 1) begin
                n_vec++;
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL early_valid: out_valid=%b required 0 before last SAD", out_valid);
                end
            end
            tick();
        end
        sad_valid = 1'b0;
    endtask

    task automatic check_result(input string name, input int ex, input int ey, input int es);
        n_vec++;
        if (out_valid !== 1'b1 || $signed(mv_x) !== ex || $signed(mv_y) !== ey || int'(min_sad) !== es) begin
            n_err++;
            $display("FAIL %s: valid=%b mv=(%0d,%0d) sad=%0d required valid=1 mv=(%0d,%0d) sad=%0d",
                     name, out_valid, $signed(mv_x), $signed(mv_y), min_sad, ex, ey, es);
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept: out_valid=%b ready=%b required 0/1", out_valid, ready);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (ready !== 1'b1 || out_valid !== 1'b0 || mv_x !== 6'd0 || mv_y !== 6'd0 ||
            min_sad !== 16'hFFFF || overrun !== 1'b0) begin
            n_err++;
            $display("FAIL reset: rdy=%b ov=%b mv=%h/%h sad=%h orun=%b required 1 0 00/00 ffff 0",
                     ready, out_valid, mv_x, mv_y, min_sad, overrun);
        end
    endtask

    task automatic test_single_min();
        fill(500);
        sads[idx_of(3, -7)] = 20;
        feed(NC, 1'b0);
        check_result("single_min", 3, -7, 20);
        accept();
    endtask

    task automatic test_tie();
        fill(200);
        sads[idx_of(-16, -16)] = 100;
        sads[idx_of(16, 16)] = 100;
        feed(NC, 1'b0);
        check_result("tie_first_wins", -16, -16, 100);
        accept();
    endtask

    task automatic test_gaps();
        for (int k = 0; k < NC; k++) sads[k] = k;
        feed(NC, 1'b1);
        check_result("index_gaps", -16, -16, 0);
        accept();
    endtask

    task automatic test_odd_col();
        fill(900);
        sads[idx_of(-15, 16)] = 1;
        feed(NC, 1'b0);
        check_result("odd_column", -15, 16, 1);
        accept();
    endtask

    task automatic test_zero_bias();
        fill(999);
        sads[idx_of(0, 0)] = 100;
        sads[idx_of(5, 5)] = 60;
        feed(NC, 1'b0);
`ifdef ME_ZERO_BIAS_EN
        check_result("zero_bias", 0, 0, 36);
`else
        check_result("zero_bias", 5, 5, 60);
`endif
        accept();
    endtask

    task automatic test_random();
        int ex, ey, es;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < NC; k++) sads[k] = $urandom_range(0, 65534);
            if (t == 1) sads[$urandom_range(0, NC - 1)] = 0;
            if (t == 2) sads[idx_of(0, 0)] = $urandom_range(0, 200);
            model_best(ex, ey, es);
            feed(NC, t != 0);
            check_result("random", ex, ey, es);
            accept();
        end
    endtask

    task automatic test_abort_overrun();
        fill(300);
        sads[5] = 7;
        feed(400, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ready !== 1'b1 || out_valid !== 1'b0 || min_sad !== 16'hFFFF) begin
            n_err++;
            $display("FAIL abort: ready=%b out_valid=%b sad=%h required 1 0 ffff", ready, out_valid, min_sad);
        end
        tick();
        rst_n = 1'b1;
        tick();
        sad_valid = 1'b1;
        sad = 16'd3;
        tick();
        sad_valid = 1'b0;
        n_vec++;
        if (overrun !== 1'b1 || min_sad !== 16'hFFFF || mv_x !== 6'd0) begin
            n_err++;
            $display("FAIL overrun_pulse: overrun=%b sad=%h mv_x=%h required 1 ffff 00", overrun, min_sad, mv_x);
        end
        tick();
        n_vec++;
        if (overrun !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_clear: overrun=%b required 0", overrun);
        end
    endtask

    task automatic test_hold();
        int ex, ey, es;
        for (int k = 0; k < NC; k++) sads[k] = $urandom_range(100, 60000);
        model_best(ex, ey, es);
        feed(NC, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check_result("hold_stable", ex, ey, es);
            if (c == 2) sad_valid = 1'b1;
            tick();
            sad_valid = 1'b0;
            if (c == 2) begin
                n_vec++;
                if (overrun !== 1'b1) begin
                    n_err++;
                    $display("FAIL hold_overrun: overrun=%b required 1", overrun);
                end
            end
        end
        check_result("hold_final", ex, ey, es);
        accept();
    endtask

    initial begin
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_single_min();
        test_tie();
        test_gaps();
        test_odd_col();
        test_zero_bias();
        test_random();
        test_abort_overrun();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
